// File: rtl/word_stable_capture.sv
// word_stable_capture: recovers an update strobe for a word that changes with no
// strobe of its own. A new value is captured once it has held for P_N_STABLE
// cycles. It is then offered once on a valid/ready interface. Words that are
// replaced before the sink takes them are counted in a saturating drop counter.
module word_stable_capture #(
  parameter int unsigned P_DATA_WIDTH = 32,
  parameter int unsigned P_N_STABLE   = 4,
  parameter int unsigned P_CNT_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [P_DATA_WIDTH-1:0] data_in,
  output logic [P_DATA_WIDTH-1:0] dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    busy,
  output logic [P_CNT_WIDTH-1:0]  drop_cnt
);

  // Settle counter sized to hold P_N_STABLE without wrapping
  localparam int unsigned CNT_W = $clog2(P_N_STABLE + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_N_STABLE);
  // With a one-cycle stability window a new value is taken straight from IDLE
  localparam bit IMMEDIATE = (P_N_STABLE == 1);

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  state_t                  state;
  logic [P_DATA_WIDTH-1:0] d_q;
  logic [P_DATA_WIDTH-1:0] cand;
  logic [P_DATA_WIDTH-1:0] last_word;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    capture;
  logic [P_DATA_WIDTH-1:0] cap_word;
  logic                    handshake;
  logic                    drop_sat;

  assign cnt_inc   = cnt + CNT_ONE;
  assign handshake = dout_valid & dout_ready;
  assign drop_sat  = &drop_cnt;
  assign busy      = (state == SETTLE) | dout_valid;

  // Input register: every comparison below works on this copy only
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= '0;
    end else begin
      d_q <= data_in;
    end
  end

  // Capture decision for the current cycle and the word it delivers
  always_comb begin
    capture  = 1'b0;
    cap_word = cand;
    case (state)
      IDLE: begin
        if (IMMEDIATE && (d_q != last_word)) begin
          capture  = 1'b1;
          cap_word = d_q;
        end
      end
      SETTLE: begin
        if ((d_q == cand) && (cnt_inc == CNT_LAST)) begin
          capture  = 1'b1;
          cap_word = cand;
        end
      end
      default: begin
        capture  = 1'b0;
        cap_word = cand;
      end
    endcase
  end

  // Stability filter: track a candidate until it holds long enough or is abandoned
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cand      <= '0;
      cnt       <= '0;
      last_word <= '0;
    end else begin
      if (capture) begin
        last_word <= cap_word;
      end
      case (state)
        IDLE: begin
          if ((d_q != last_word) && !IMMEDIATE) begin
            cand  <= d_q;
            cnt   <= CNT_ONE;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (d_q == cand) begin
            cnt <= cnt_inc;
            if (cnt_inc == CNT_LAST) begin
              state <= IDLE;
            end
          end else if (d_q == last_word) begin
            // Input fell back to the delivered word: treat as a glitch
            state <= IDLE;
          end else begin
            cand <= d_q;
            cnt  <= CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output holding register with newest-wins overwrite and drop counting
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (capture) begin
        dout       <= cap_word;
        dout_valid <= 1'b1;
        if (dout_valid && !dout_ready && !drop_sat) begin
          drop_cnt <= drop_cnt + P_CNT_WIDTH'(1);
        end
      end else if (handshake) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_word_stable_capture.sv
// Bench for word_stable_capture: table of directed vectors, hand-written corner
// sequences and random stimulus, all checked against a run-length reference model.
module tb_word_stable_capture;

  logic        clk;
  logic        rst;
  logic [31:0] data_in;
  logic        dout_ready;

  logic [31:0] dout1;
  logic        dout_valid1;
  logic        busy1;
  logic [7:0]  drop1;

  logic [31:0] dout2;
  logic        dout_valid2;
  logic        busy2;
  logic [1:0]  drop2;

  int n_cmp = 0;
  int n_bad = 0;

  // Default configuration
  word_stable_capture #(.P_DATA_WIDTH(32), .P_N_STABLE(4), .P_CNT_WIDTH(8)) dut1 (
    .clk(clk), .rst(rst), .data_in(data_in), .dout(dout1), .dout_valid(dout_valid1),
    .dout_ready(dout_ready), .busy(busy1), .drop_cnt(drop1)
  );

  // Immediate capture and a narrow drop counter
  word_stable_capture #(.P_DATA_WIDTH(32), .P_N_STABLE(1), .P_CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .data_in(data_in), .dout(dout2), .dout_valid(dout_valid2),
    .dout_ready(dout_ready), .busy(busy2), .drop_cnt(drop2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a value is captured in the cycle it has been seen for n
  // consecutive cycles, provided it differs from the last captured value.
  typedef struct {
    logic [31:0] dq;
    logic [31:0] last;
    logic [31:0] dout;
    int          run;
    logic        valid;
    logic        settle;
    int          drop;
  } model_t;

  model_t m1 = '{dq: 0, last: 0, dout: 0, run: 1, valid: 0, settle: 0, drop: 0};
  model_t m2 = '{dq: 0, last: 0, dout: 0, run: 1, valid: 0, settle: 0, drop: 0};

  function automatic model_t mstep(model_t m, logic r, logic [31:0] din, logic rdy,
                                   int n, int cw);
    model_t x;
    bit cap;
    x = m;
    if (r) begin
      x.dq = 0; x.last = 0; x.dout = 0; x.run = 1;
      x.valid = 0; x.settle = 0; x.drop = 0;
      return x;
    end
    cap = (m.dq != m.last) && (m.run == n);
    x.dq = din;
    x.run = (din == m.dq) ? ((m.run < 1000) ? m.run + 1 : m.run) : 1;
    if (cap) x.last = m.dq;
    x.settle = (m.dq != m.last) && !cap;
    if (cap) begin
      x.dout = m.dq;
      x.valid = 1'b1;
      if (m.valid && !rdy && (m.drop < (1 << cw) - 1)) x.drop = m.drop + 1;
    end else if (m.valid && rdy) begin
      x.valid = 1'b0;
    end
    return x;
  endfunction

  always @(posedge clk) begin
    m1 <= mstep(m1, rst, data_in, dout_ready, 4, 8);
    m2 <= mstep(m2, rst, data_in, dout_ready, 1, 2);
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic check_models();
    cmp("n4.valid", 32'(dout_valid1), 32'(m1.valid));
    cmp("n4.dout",  dout1, m1.dout);
    cmp("n4.busy",  32'(busy1), 32'(m1.settle | m1.valid));
    cmp("n4.drop",  32'(drop1), 32'(m1.drop));
    cmp("n1.valid", 32'(dout_valid2), 32'(m2.valid));
    cmp("n1.dout",  dout2, m2.dout);
    cmp("n1.busy",  32'(busy2), 32'(m2.settle | m2.valid));
    cmp("n1.drop",  32'(drop2), 32'(m2.drop));
  endtask

  // Drive one cycle from a negedge, then check on the following negedge
  task automatic apply(input logic r, input logic [31:0] d, input logic rdy);
    rst = r;
    data_in = d;
    dout_ready = rdy;
    @(negedge clk);
    check_models();
  endtask

  typedef struct {
    logic        r;
    logic [31:0] din;
    logic        rdy;
    bit          chk;
    logic        ev;
    logic [31:0] ed;
    logic        eb;
    logic [7:0]  edrop;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [31:0] din, input logic rdy, input bit chk,
                     input logic ev, input logic [31:0] ed, input logic eb, input logic [7:0] edrop);
    vec_t v;
    v.r = r; v.din = din; v.rdy = rdy; v.chk = chk;
    v.ev = ev; v.ed = ed; v.eb = eb; v.edrop = edrop;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] pool [8];
    logic [31:0] cur;
    int hold;

    rst = 1'b1;
    data_in = '0;
    dout_ready = 1'b1;

    // Reset state, then idle to cycle 10
    add(1, 32'h0, 1, 1, 0, 32'h0, 0, 8'd0);
    for (int i = 1; i < 10; i++) add(0, 32'h0, 1, 0, 0, 0, 0, 0);
    // Single word, sink always ready: valid only in cycle 15
    add(0, 32'hA5A5_0001, 1, 1, 0, 32'h0, 0, 8'd0);
    for (int i = 0; i < 3; i++) add(0, 32'hA5A5_0001, 1, 1, 0, 32'h0, 1, 8'd0);
    add(0, 32'hA5A5_0001, 1, 1, 1, 32'hA5A5_0001, 1, 8'd0);
    add(0, 32'hA5A5_0001, 1, 1, 0, 32'hA5A5_0001, 0, 8'd0);
    add(0, 32'hA5A5_0001, 1, 1, 0, 32'hA5A5_0001, 0, 8'd0);
    // Return input to zero so zero becomes the delivered word
    for (int i = 0; i < 6; i++) add(0, 32'h0, 1, 0, 0, 0, 0, 0);
    add(0, 32'h0, 1, 1, 0, 32'h0, 0, 8'd0);
    // Two-cycle glitch back to the delivered word: nothing delivered
    add(0, 32'h11, 1, 1, 0, 32'h0, 0, 8'd0);
    add(0, 32'h11, 1, 1, 0, 32'h0, 1, 8'd0);
    add(0, 32'h0, 1, 1, 0, 32'h0, 1, 8'd0);
    for (int i = 0; i < 4; i++) add(0, 32'h0, 1, 1, 0, 32'h0, 0, 8'd0);
    // Short 0x11 then 0x22 held: one delivery of 0x22
    add(0, 32'h11, 1, 1, 0, 32'h0, 0, 8'd0);
    add(0, 32'h11, 1, 1, 0, 32'h0, 1, 8'd0);
    add(0, 32'h22, 1, 1, 0, 32'h0, 1, 8'd0);
    for (int i = 0; i < 3; i++) add(0, 32'h22, 1, 1, 0, 32'h0, 1, 8'd0);
    add(0, 32'h22, 1, 1, 1, 32'h22, 1, 8'd0);
    add(0, 32'h22, 1, 1, 0, 32'h22, 0, 8'd0);
    add(0, 32'h22, 1, 1, 0, 32'h22, 0, 8'd0);
    // Sink stalled: 0x1 overwritten by 0x2, one drop
    add(0, 32'h1, 0, 1, 0, 32'h22, 0, 8'd0);
    for (int i = 0; i < 3; i++) add(0, 32'h1, 0, 1, 0, 32'h22, 1, 8'd0);
    add(0, 32'h1, 0, 1, 1, 32'h1, 1, 8'd0);
    add(0, 32'h1, 0, 1, 1, 32'h1, 1, 8'd0);
    for (int i = 0; i < 4; i++) add(0, 32'h2, 0, 1, 1, 32'h1, 1, 8'd0);
    add(0, 32'h2, 0, 1, 1, 32'h2, 1, 8'd1);
    add(0, 32'h2, 0, 1, 1, 32'h2, 1, 8'd1);
    add(0, 32'h2, 1, 1, 0, 32'h2, 0, 8'd1);
    add(0, 32'h2, 0, 1, 0, 32'h2, 0, 8'd1);
    // Word pending plus another mid-settle, then a one-cycle reset
    for (int i = 0; i < 6; i++) add(0, 32'h3, 0, 0, 0, 0, 0, 0);
    add(0, 32'h4, 0, 0, 0, 0, 0, 0);
    add(0, 32'h4, 0, 0, 0, 0, 0, 0);
    add(1, 32'h33, 0, 1, 0, 32'h0, 0, 8'd0);
    add(0, 32'h33, 0, 1, 0, 32'h0, 0, 8'd0);
    for (int i = 0; i < 3; i++) add(0, 32'h33, 0, 1, 0, 32'h0, 1, 8'd0);
    add(0, 32'h33, 0, 1, 1, 32'h33, 1, 8'd0);
    add(0, 32'h33, 0, 1, 1, 32'h33, 1, 8'd0);

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].r, tbl[i].din, tbl[i].rdy);
      if (tbl[i].chk) begin
        cmp($sformatf("vec%0d.valid", i), 32'(dout_valid1), 32'(tbl[i].ev));
        cmp($sformatf("vec%0d.dout", i), dout1, tbl[i].ed);
        cmp($sformatf("vec%0d.busy", i), 32'(busy1), 32'(tbl[i].eb));
        cmp($sformatf("vec%0d.drop", i), 32'(drop1), 32'(tbl[i].edrop));
      end
    end

    // Narrow counter saturation with immediate capture, sink stalled
    for (int w = 0; w < 6; w++) begin
      apply(0, 32'h100 + 32'(w), 0);
      apply(0, 32'h100 + 32'(w), 0);
    end
    cmp("sat.drop", 32'(drop2), 32'd3);
    cmp("sat.dout", dout2, 32'h105);
    cmp("sat.valid", 32'(dout_valid2), 32'd1);
    apply(1, 32'h105, 0);
    cmp("rst.n1.valid", 32'(dout_valid2), 32'd0);
    cmp("rst.n1.drop", 32'(drop2), 32'd0);
    cmp("rst.n1.dout", dout2, 32'd0);
    cmp("rst.n4.busy", 32'(busy1), 32'd0);

    // One-cycle window: valid two cycles after the input edge
    apply(0, 32'h0, 1);
    apply(0, 32'h77, 1);
    cmp("n1.lat0", 32'(dout_valid2), 32'd0);
    apply(0, 32'h77, 1);
    cmp("n1.lat1", 32'(dout_valid2), 32'd1);
    cmp("n1.latd", dout2, 32'h77);

    // Random: words held for random lengths, random ready, occasional reset
    pool[0] = 32'h0;        pool[1] = 32'h1;        pool[2] = 32'h2;
    pool[3] = 32'hDEAD_BEEF; pool[4] = 32'hFFFF_FFFF; pool[5] = 32'h8000_0000;
    pool[6] = 32'h1234_5678; pool[7] = 32'h0000_00FF;
    cur = 32'h0;
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        cur = pool[$urandom_range(0, 7)];
        hold = $urandom_range(1, 7);
      end
      hold--;
      apply(($urandom_range(0, 249) == 0), cur, ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
